// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control-symbol constants, {C1,C0} decode and counter width default.
package tmds_pkg;
  localparam int CNT_BITS_DEF = 12;
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;
  function automatic logic [2:0] ctrl_decode(input logic [9:0] sym);
    return sym == CTRL_00 ? 3'b100 :
           sym == CTRL_01 ? 3'b101 :
           sym == CTRL_10 ? 3'b110 :
           sym == CTRL_11 ? 3'b111 : 3'b000;
  endfunction
endpackage

// File: rtl/tmds_decode_chan.sv
// tmds_decode_chan: one TMDS channel, 10-bit symbol to registered data/is_ctrl/ctrl.
module tmds_decode_chan import tmds_pkg::*; (
  input  logic       i_pixclk,
  input  logic       i_reset,
  input  logic [9:0] sym,
  output logic [7:0] data,
  output logic       is_ctrl,
  output logic [1:0] ctrl
);
  logic [7:0] q, d;
  logic [2:0] c;
  always_comb begin
    q = sym[9] ? ~sym[7:0] : sym[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = sym[8] ? q[i] ^ q[i-1] : ~(q[i] ^ q[i-1]);
    c = ctrl_decode(sym);
  end
  always_ff @(posedge i_pixclk)
    if (i_reset) {data, is_ctrl, ctrl} <= {8'h00, 1'b1, 2'b00};
    else {data, is_ctrl, ctrl} <= {c[2] ? 8'h00 : d, c};
endmodule

// File: rtl/tmds_rx_decoder.sv
// tmds_rx_decoder: 3-channel TMDS decode with held sync, line/frame/err pulses.
// TMDS_RX_MEASURE_EN builds width/height/lock measurement; otherwise those outputs are 0.
module tmds_rx_decoder import tmds_pkg::*; #(
  parameter int CNT_BITS    = CNT_BITS_DEF,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                i_pixclk,
  input  logic                i_reset,
  input  logic [9:0]          i_TMDS_red,
  input  logic [9:0]          i_TMDS_grn,
  input  logic [9:0]          i_TMDS_blu,
  output logic [7:0]          o_red,
  output logic [7:0]          o_grn,
  output logic [7:0]          o_blu,
  output logic                o_de,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_newline,
  output logic                o_newframe,
  output logic                o_err,
  output logic [CNT_BITS-1:0] o_width,
  output logic [CNT_BITS-1:0] o_height,
  output logic                o_locked
);
  logic [9:0] red_q, grn_q, blu_q;
  logic [7:0] red_d, grn_d, blu_d;
  logic       red_ctl, grn_ctl, blu_ctl;
  logic [1:0] unused_red_c, unused_grn_c, blu_c;
  logic       hs_q, vs_q, de_q;
  always_ff @(posedge i_pixclk)
    if (i_reset) {red_q, grn_q, blu_q} <= {3{CTRL_00}};
    else {red_q, grn_q, blu_q} <= {i_TMDS_red, i_TMDS_grn, i_TMDS_blu};
  tmds_decode_chan u_red (.i_pixclk, .i_reset, .sym(red_q), .data(red_d), .is_ctrl(red_ctl), .ctrl(unused_red_c));
  tmds_decode_chan u_grn (.i_pixclk, .i_reset, .sym(grn_q), .data(grn_d), .is_ctrl(grn_ctl), .ctrl(unused_grn_c));
  tmds_decode_chan u_blu (.i_pixclk, .i_reset, .sym(blu_q), .data(blu_d), .is_ctrl(blu_ctl), .ctrl(blu_c));
  always_comb begin
    o_de       = ~blu_ctl;
    o_red      = o_de ? red_d : 8'h00;
    o_grn      = o_de ? grn_d : 8'h00;
    o_blu      = o_de ? blu_d : 8'h00;
    o_hsync    = blu_ctl ? blu_c[0] : hs_q;
    o_vsync    = blu_ctl ? blu_c[1] : vs_q;
    o_newline  = de_q & ~o_de;
    o_newframe = o_vsync & ~vs_q;
    o_err      = (red_ctl ^ blu_ctl) | (grn_ctl ^ blu_ctl);
  end
  always_ff @(posedge i_pixclk)
    if (i_reset) {hs_q, vs_q, de_q} <= 3'b000;
    else {hs_q, vs_q, de_q} <= {o_hsync, o_vsync, o_de};
`ifdef TMDS_RX_MEASURE_EN
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [MW-1:0] LOCK = MW'(LOCK_FRAMES);
  localparam logic [MW-1:0] M_ONE = MW'(1);
  localparam logic [CNT_BITS-1:0] MAX = '1;
  localparam logic [CNT_BITS-1:0] ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
  logic [CNT_BITS-1:0] pix, len, lines, len_n;
  logic [MW-1:0]       matches;
  logic                bad, bad_n, armed, match, de_rise;
  // a line ending on the same cycle as vsync rise must still count toward this frame
  always_comb begin
    de_rise = o_de & ~de_q;
    len_n   = o_newline ? pix : len;
    bad_n   = bad | (o_newline & (pix == MAX || (lines > ONE && pix != len)));
    match   = armed && len_n != '0 && lines != '0 && len_n != MAX && lines != MAX &&
              len_n == o_width && lines == o_height && !bad_n;
  end
  always_ff @(posedge i_pixclk)
    if (i_reset) begin
      {pix, len, lines, o_width, o_height, matches, bad, armed} <= '0;
    end else begin
      if (de_rise) pix <= ONE;
      else if (o_de && pix != MAX) pix <= pix + ONE;
      if (de_rise && lines != MAX) lines <= lines + ONE;
      len <= len_n;
      bad <= bad_n;
      if (o_newframe) begin
        {len, lines, bad} <= '0;
        armed <= 1'b1;
        if (armed) begin
          o_width  <= len_n;
          o_height <= lines;
          matches  <= !match ? '0 : matches == LOCK ? LOCK : matches + M_ONE;
        end
      end
    end
  assign o_locked = matches == LOCK;
`else
  assign o_width  = '0;
  assign o_height = '0;
  assign o_locked = 1'b0;
`endif
endmodule
